seq_mul32: RTL
==============

Name: seq_mul32

Overview:
- Iterative shift-add multiplier sitting directly downstream of the 32x32 register file.
- Consumes the two register-file read operands (ReadData1/ReadData2) and produces a 64-bit product.
- Writes the low product word back into the register file through its WriteData/WriteReg/RegWrite port.
- Provides the multiply instruction for the basic 32-bit computer without adding a combinational 32x32 array.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH; iteration count equals WIDTH.
- ADDR_W, 5, register-file address width for dest_reg/WriteReg.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- op_a  input  WIDTH  multiplicand, driven from register file ReadData1.
- op_b  input  WIDTH  multiplier, driven from register file ReadData2.
- dest_reg  input  ADDR_W  destination register index for the low product word.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle completion pulse.
- result_hi  output  WIDTH  upper product word; held until next start.
- result_lo  output  WIDTH  lower product word; held until next start.
- WriteData  output  WIDTH  to register file WriteData; equals result_lo.
- WriteReg  output  ADDR_W  to register file WriteReg; latched dest_reg.
- RegWrite  output  1  to register file RegWrite; one-cycle pulse.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: state IDLE; busy=0, done=0, RegWrite=0; result_hi, result_lo, WriteData = 0; WriteReg = 0; iteration counter = 0.
- IDLE, start=1 at edge E0:
  - Latch op_a, op_b, dest_reg.
  - Clear the accumulator and counter.
  - Go to RUN; busy=1 from E0.
- RUN, one iteration per edge:
  - If the multiplier LSB is 1, add the multiplicand to the upper half of the {hi,lo} accumulator, keeping the carry.
  - Shift the 2*WIDTH+1-bit value right by 1; increment the counter.
- After the WIDTH-th iteration (edge E0+WIDTH):
  - Go to DONE; result_hi/result_lo hold the final product.
  - done=1 and RegWrite=1 for exactly one cycle, from E0+WIDTH to E0+WIDTH+1.
  - WriteData=result_lo and WriteReg=latched dest_reg are stable for that whole cycle.
- DONE -> IDLE unconditionally at the next edge; busy=0 and start is accepted again from that cycle.
- Latency: fixed WIDTH+1 cycles start-to-IDLE, independent of operand values; zero operands do not shorten it.
- RegWrite, WriteData and WriteReg come straight from flops, glitch-free. The register file ANDs RegWrite with clk, so no combinational path to RegWrite is allowed.
- start while busy (RUN or DONE) is ignored; no queueing and no effect on the in-flight operation.
- Operand inputs may change freely after E0; only the latched copies are used.
- dest_reg=0 writes register 0 like any other register; no suppression.
- Reset mid-RUN: IDLE at the next edge; no done, no RegWrite; results cleared to 0.
- Reset in DONE: reset dominates; RegWrite deasserts at that edge.
- start and reset both high: reset wins.

Optional Feature:
- Macro: MUL_SIGNED_EN.
- Defined:
  - Adds input port is_signed (1 bit), latched at start.
  - When is_signed=1, operands are two's complement. Multiply the magnitudes, then negate the 2*WIDTH product before entering DONE if the operand signs differ.
  - Latency is unchanged (WIDTH+1).
  - -2^31 is handled as magnitude 2^31.
- Not defined: is_signed port absent; all operations unsigned.

Test Plan:
- Assert reset 2 cycles with start=1 -> busy=0, done=0, RegWrite=0, result_hi=result_lo=0, WriteData=0; no operation starts.
- op_a=3, op_b=5, dest_reg=7, start pulsed at E0 -> done and RegWrite high for one cycle after E0+32; WriteData=0x0000000F, WriteReg=7, result_hi=0; back in IDLE after E0+33.
- op_a=op_b=0xFFFFFFFF -> result_hi=0xFFFFFFFE, result_lo=0x00000001, latency 33.
- Start 3*5; at E0+10 pulse start with 9*9 and change op_a/op_b -> result_lo=15, a single RegWrite pulse, second request ignored.
- Start 7*7, assert reset at E0+10 for one cycle -> no done, no RegWrite, results 0; new start after release gives correct product.
- op_a=0xFFFFFFFE, op_b=3 -> unsigned: result_hi=0x00000002, result_lo=0xFFFFFFFA. With MUL_SIGNED_EN and is_signed=1: result_hi=0xFFFFFFFF, result_lo=0xFFFFFFFA.

Source files
------------

// File: rtl/seq_mul32.sv
// seq_mul32: iterative shift-add 32x32 multiplier feeding the register-file write port.
// Optional macro MUL_SIGNED_EN adds an is_signed input for two's-complement operands.
module seq_mul32 #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WIDTH-1:0]  op_a,
  input  logic [WIDTH-1:0]  op_b,
  input  logic [ADDR_W-1:0] dest_reg,
`ifdef MUL_SIGNED_EN
  input  logic              is_signed,
`endif
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  result_hi,
  output logic [WIDTH-1:0]  result_lo,
  output logic [WIDTH-1:0]  WriteData,
  output logic [ADDR_W-1:0] WriteReg,
  output logic              RegWrite
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;
  logic               neg_q;

  logic               signed_op;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     add_sum;
  logic [2*WIDTH-1:0] acc_shift;
  logic [2*WIDTH-1:0] prod_final;
  logic               start_go;
  logic               last_iter;

`ifdef MUL_SIGNED_EN
  assign signed_op = is_signed;
`else
  assign signed_op = 1'b0;
`endif

  // Magnitudes of the operands; the most negative value maps to 2^(WIDTH-1) unchanged.
  assign a_neg = signed_op & op_a[WIDTH-1];
  assign b_neg = signed_op & op_b[WIDTH-1];
  assign a_mag = a_neg ? (~op_a + 1'b1) : op_a;
  assign b_mag = b_neg ? (~op_b + 1'b1) : op_b;

  // The adder keeps its carry, so the shifted {carry,hi,lo} value never loses a bit.
  assign add_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
  assign acc_shift  = {add_sum, acc[WIDTH-1:1]};
  assign prod_final = neg_q ? (~acc_shift + 1'b1) : acc_shift;

  assign start_go  = (state == S_IDLE) && start;
  assign last_iter = (state == S_RUN) && (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every always_comb output is given a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_go)  state_nxt = S_RUN;
      S_RUN:   if (last_iter) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand     <= '0;
      acc       <= '0;
      cnt       <= '0;
      neg_q     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      RegWrite  <= 1'b0;
      result_hi <= '0;
      result_lo <= '0;
      WriteData <= '0;
      WriteReg  <= '0;
    end else begin
      done     <= 1'b0;
      RegWrite <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_go) begin
            mcand    <= a_mag;
            acc      <= {{WIDTH{1'b0}}, b_mag};
            cnt      <= '0;
            neg_q    <= a_neg ^ b_neg;
            WriteReg <= dest_reg;
            busy     <= 1'b1;
          end
        end
        S_RUN: begin
          acc <= acc_shift;
          cnt <= cnt + CNT_W'(1);
          if (last_iter) begin
            result_hi <= prod_final[2*WIDTH-1:WIDTH];
            result_lo <= prod_final[WIDTH-1:0];
            WriteData <= prod_final[WIDTH-1:0];
            done      <= 1'b1;
            RegWrite  <= 1'b1;
          end
        end
        S_DONE: begin
          busy <= 1'b0;
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
